// File: rtl/cpu_hatch_arb.sv
// cpu_hatch_arb: round-robin arbiter sharing the hatch instruction-memory port
// between NREQ fetch requesters. One grant per cycle, pipelined reads with a
// {valid, id} tag pipeline that routes each response back to its requester.
// Per-requester flush squashes in-flight responses.
// Optional feature: define HATCH_ARB_LOCK_EN to let a locked requester keep
// top priority (req_lock); without it req_lock is ignored.
module cpu_hatch_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 48,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ-1:0]   flush,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     hatch_address,
  input  logic [DW-1:0]     hatch_instruction
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]          ptr_q, ptr_d;
  logic [AW-1:0]          hatch_address_q, hatch_address_d;
  logic [LAT:0]           tag_v_q, tag_v_d;
  logic [LAT:0][PW-1:0]   tag_id_q, tag_id_d;
  logic [NREQ-1:0]        rvalid_q, rvalid_d;
  logic [DW-1:0]          rdata_q, rdata_d;

  logic                   found;
  logic                   grant_valid;
  logic [PW-1:0]          win;
  logic [PW-1:0]          cand;
  logic [PW-1:0]          win_inc;

`ifndef HATCH_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // Round-robin search starting at ptr; first requester with req set wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grant is suppressed while reset is asserted.
  assign grant_valid = found & ~rst;
  assign win_inc     = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

  // One-hot grant, pointer update and address capture.
  always_comb begin
    gnt             = '0;
    ptr_d           = ptr_q;
    hatch_address_d = hatch_address_q;
    if (grant_valid) begin
      gnt[win]        = 1'b1;
      hatch_address_d = req_addr[int'(win)*AW +: AW];
`ifdef HATCH_ARB_LOCK_EN
      ptr_d           = req_lock[win] ? win : win_inc;
`else
      ptr_d           = win_inc;
`endif
    end
  end

  // Tag pipeline shift with flush squashing, and output-stage decode.
  always_comb begin
    tag_v_d     = '0;
    tag_id_d    = tag_id_q;
    tag_v_d[0]  = grant_valid & ~flush[win];
    tag_id_d[0] = win;
    for (int s = 1; s <= LAT; s++) begin
      tag_v_d[s]  = tag_v_q[s-1] & ~flush[tag_id_q[s-1]];
      tag_id_d[s] = tag_id_q[s-1];
    end
    rvalid_d = '0;
    if (tag_v_q[LAT] && !flush[tag_id_q[LAT]]) begin
      rvalid_d[tag_id_q[LAT]] = 1'b1;
    end
    rdata_d = hatch_instruction;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q           <= '0;
      hatch_address_q <= '0;
      tag_v_q         <= '0;
      // NOTE: the tag ids are reset as well even though the valid bits alone
      // gate them; it is a handful of flops and keeps X out of simulation.
      tag_id_q        <= '0;
      rvalid_q        <= '0;
      rdata_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values together, independent of statement order.
      ptr_q           <= ptr_d;
      hatch_address_q <= hatch_address_d;
      tag_v_q         <= tag_v_d;
      tag_id_q        <= tag_id_d;
      rvalid_q        <= rvalid_d;
      rdata_q         <= rdata_d;
    end
  end

  assign rvalid        = rvalid_q;
  assign rdata         = rdata_q;
  assign hatch_address = hatch_address_q;

endmodule

// File: doc/cpu_hatch_arb.md
# cpu_hatch_arb

Round-robin arbiter that shares the single hatch instruction-memory port (`hatch_address` / `hatch_instruction`) between several fetch requesters, e.g. multiple `cpu_fetch` instances or a fetch unit plus a loader/debug reader. Grants are issued one per cycle, memory reads are pipelined, and each response is routed back to the requester that issued the address. A per-requester flush discards in-flight responses after a branch kill, in the same way `kill_4a` squashes fetch.

## Interface
- `NREQ`, default 4: number of requesters; valid range 2–8.
- `AW`, default 32: address width.
- `DW`, default 48: instruction width.
- `LAT`, default 2: fixed hatch read latency in cycles; valid range 1–4.

Ports:
- `clk`  in  1  : the single clock; all state changes on its rising edge.
- `rst`  in  1  : reset; asynchronous, active-high.
- `req`  in  NREQ  : request bits; a requester holds its bit and its address stable until it sees its grant.
- `req_addr`  in  NREQ*AW  : request addresses; requester i uses bits [i*AW +: AW].
- `req_lock`  in  NREQ  : lock request bits; only used with `HATCH_ARB_LOCK_EN`.
- `flush`  in  NREQ  : per-requester flush; drops that requester's in-flight responses.
- `gnt`  out  NREQ  : one-hot grant, combinational; the request is accepted in this cycle.
- `rvalid`  out  NREQ  : one-hot response valid, registered.
- `rdata`  out  DW  : response instruction, registered; meaningful only when `rvalid` is non-zero.
- `hatch_address`  out  AW  : registered address to instruction memory.
- `hatch_instruction`  in  DW  : memory data for the address presented `LAT` cycles earlier.

## Operation
- **Round-robin pointer:** `ptr`, range 0..NREQ-1. The search order is ptr, ptr+1, …, wrapping mod NREQ. The first requester with `req` set wins, and `gnt` is that requester's bit alone.
- **Pointer update:** after granting requester i, `ptr` becomes (i+1) mod NREQ. With no grant, `ptr` holds.
- **Address issue:** on each grant, `hatch_address` is loaded with the winner's address on the next edge. When there is no grant, `hatch_address` holds its last value.
- **Tag pipeline:** a tag pipeline of depth LAT+1 carries {valid, id} for each issued address. At the output stage:
  - `rdata` is loaded from `hatch_instruction`;
  - `rvalid` is loaded with onehot(id) if the tag is valid, and 0 otherwise.
- **Flush:** `flush[i]` clears the valid bit of every pipeline entry with id i, including the entry being created by a grant to i in the same cycle. That grant still issues its address, but no response is ever delivered for it. Entries for other ids are unaffected.
- **Ordering:** responses return in grant order, at most one per cycle. Back-to-back grants sustain full throughput.
- **Reset values:** `gnt`=0 while `rst` is high; `rvalid`=0; `rdata`=0; `hatch_address`=0; `ptr`=0; all tag valids=0.
- **Reset mid-operation:** every in-flight read is discarded, and no `rvalid` is produced for it after release.
- **Degenerate cases:**
  - A request with `req` low is never granted, whatever its `req_lock`.
  - With `req`=0, no tag is created and the pipeline drains normally.

## Timing
- Cycle t: `req[i]` is high and i wins, so `gnt[i]`=1 combinationally in cycle t.
- Cycle t+1: `hatch_address` = `req_addr[i]`.
- Cycle t+1+LAT: `hatch_instruction` carries the data.
- Cycle t+2+LAT: `rvalid[i]`=1 and `rdata` = that data, for one cycle.
- Grant-to-response latency is therefore LAT+2 cycles.
- A flush that takes effect in any cycle from t through t+1+LAT suppresses the response. A flush in cycle t+2+LAT is too late, and the response is delivered.
- Requesters may drop `req` in the cycle after their grant, or keep it high to request again.

## Configuration
- **`HATCH_ARB_LOCK_EN` defined:** if requester i is granted while `req_lock[i]`=1, `ptr` becomes i instead of i+1. Requester i therefore keeps top priority while it continues to request with lock held. Dropping `req[i]` or `req_lock[i]` lets the pointer resume rotation from i+1 on its next grant to i. Absence of a request simply lets others win under the normal search.
- **`HATCH_ARB_LOCK_EN` undefined:** `req_lock` is ignored and the pointer always advances to i+1.

## Test plan
- **Single read:** NREQ=4, LAT=2, reset then `req`=0001 with addr0=0x100.
  - Cycle 0: `gnt`=0001.
  - Cycle 1: `hatch_address`=0x100.
  - Cycle 3: model drives 0xABC.
  - Cycle 4: `rvalid`=0001 and `rdata`=0xABC, then 0 in cycle 5.
- **Full contention:** `req`=1111 held high with distinct addresses.
  - Grants go 0,1,2,3,0,1 in consecutive cycles.
  - `rvalid` follows the same order one-hot, starting at cycle 4, with no gaps.
- **Wrap-around:** after a grant to 1 (`ptr`=2), assert `req`=0011 → grant to 0, then `ptr`=1 → grant to 1 next.
- **Flush:** grant to 0 in cycle 0 and to 1 in cycle 1; pulse `flush[1]` in cycle 2.
  - `rvalid`=0001 in cycle 4.
  - `rvalid`=0000 in cycle 5.
  - `hatch_address` still showed addr1 in cycle 2.
- **Reset mid-flight:** two grants issued, then `rst` pulsed in the next cycle.
  - `rvalid` stays 0 and `hatch_address`=0.
  - After release, `req`=1111 is granted to 0 first.
- **Lock:** with `HATCH_ARB_LOCK_EN`, `req`=0111 and `req_lock`=0100 starting with `ptr`=2 → grants 2,2,2. Without the define, the same stimulus gives 2,0,1,2.
